data_cache: RTL and testbench



---
 rtl/data_cache.sv | 99 +++++++++
 tb/tb_data_cache.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// 64-byte little-endian load/store memory with RISC-V funct3 access sizes and wrap-around addressing.
// Optional alignment checking (misaligned port, suppressed access) is enabled by DATA_CACHE_ALIGN_CHECK_EN.
module data_cache (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic [2:0]  width,
  input  logic [5:0]  select,
`ifdef DATA_CACHE_ALIGN_CHECK_EN
  output logic        misaligned,
`endif
  output logic [31:0] out,
  input  logic [31:0] in
);

  localparam logic [2:0] W_LB  = 3'b000;
  localparam logic [2:0] W_LH  = 3'b001;
  localparam logic [2:0] W_LW  = 3'b010;
  localparam logic [2:0] W_LBU = 3'b100;
  localparam logic [2:0] W_LHU = 3'b101;

  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        access_ok;
  logic        store_en;
  logic [3:0]  lane_en;
  logic [5:0]  lane_addr [4];
  logic [7:0]  rd_byte [4];
  logic [7:0]  mem_reg [64];
  logic [63:0] byte_we;
  logic [7:0]  byte_wdata [64];

  assign is_byte = (width == W_LB) || (width == W_LBU);
  assign is_half = (width == W_LH) || (width == W_LHU);
  assign is_word = (width == W_LW);

`ifdef DATA_CACHE_ALIGN_CHECK_EN
  assign misaligned = (is_half && select[0]) || (is_word && (select[1:0] != 2'b00));
  assign access_ok  = ~misaligned;
`else
  assign access_ok  = 1'b1;
`endif

  assign store_en = ~mode & access_ok;
  assign lane_en  = {4{store_en}} & {is_word, is_word, is_word | is_half, is_byte | is_half | is_word};

  // Lane k of an access addresses byte select+k; 6-bit addition provides the 63 -> 0 wrap.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_addr[gi] = select + 6'(gi);
      assign rd_byte[gi]   = mem_reg[lane_addr[gi]];
    end
  endgenerate

  // Lanes always hit distinct bytes, so at most one hit bit per byte is set.
  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_byte
      logic [3:0] hit;
      for (genvar gk = 0; gk < 4; gk++) begin : g_hit
        assign hit[gk] = lane_en[gk] && (lane_addr[gk] == 6'(gi));
      end
      assign byte_we[gi]    = |hit;
      assign byte_wdata[gi] = ({8{hit[0]}} & in[7:0])   |
                              ({8{hit[1]}} & in[15:8])  |
                              ({8{hit[2]}} & in[23:16]) |
                              ({8{hit[3]}} & in[31:24]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 64; i++) begin
        if (byte_we[i]) begin
          mem_reg[i] <= byte_wdata[i];
        end
      end
    end
  end

  always_comb begin
    out = '0;
    if (mode && access_ok) begin
      case (width)
        W_LB:    out = {{24{rd_byte[0][7]}}, rd_byte[0]};
        W_LBU:   out = {24'h0, rd_byte[0]};
        W_LH:    out = {{16{rd_byte[1][7]}}, rd_byte[1], rd_byte[0]};
        W_LHU:   out = {16'h0, rd_byte[1], rd_byte[0]};
        W_LW:    out = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
        default: out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus randomized loads/stores/resets
// compared against a byte-array reference model.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [2:0]  width;
  logic [5:0]  select;
  logic [31:0] out;
  logic [31:0] in_data;
`ifdef DATA_CACHE_ALIGN_CHECK_EN
  logic        misaligned;
`endif

  data_cache dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .width      (width),
    .select     (select),
`ifdef DATA_CACHE_ALIGN_CHECK_EN
    .misaligned (misaligned),
`endif
    .out        (out),
    .in         (in_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int model [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_mis(input logic [2:0] w, input int sel);
    bit m;
    m = ((w == 3'd1 || w == 3'd5) && (sel % 2 != 0)) || (w == 3'd2 && (sel % 4 != 0));
`ifdef DATA_CACHE_ALIGN_CHECK_EN
    return m;
`else
    return m && 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] w, input int sel);
    int b, h;
    longint wd;
    b  = model[sel % 64];
    h  = b + 256 * model[(sel + 1) % 64];
    wd = longint'(h) + 65536 * longint'(model[(sel + 2) % 64])
         + 16777216 * longint'(model[(sel + 3) % 64]);
    if (is_mis(w, sel)) return 32'h0;
    case (w)
      3'd0:    return 32'(b >= 128 ? b - 256 : b);
      3'd4:    return 32'(b);
      3'd1:    return 32'(h >= 32768 ? h - 65536 : h);
      3'd5:    return 32'(h);
      3'd2:    return 32'(wd);
      default: return 32'h0;
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] w, input int sel, input logic [31:0] data);
    int n;
    case (w)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      3'd2:       n = 4;
      default:    n = 0;
    endcase
    if (is_mis(w, sel)) n = 0;
    for (int k = 0; k < n; k++) model[(sel + k) % 64] = int'((data >> (8 * k)) & 32'hff);
  endtask

  task automatic load_chk(input logic [2:0] w, input int sel, input logic [31:0] exp, input string tag);
    @(negedge clk);
    mode   = 1'b1;
    width  = w;
    select = 6'(sel);
    #1;
    $display("load  w=%0d sel=%0d out=%h exp=%h", w, sel, out, exp);
    check(tag, out, exp);
`ifdef DATA_CACHE_ALIGN_CHECK_EN
    check({tag, "_mis"}, 32'(misaligned), 32'(is_mis(w, sel)));
`endif
  endtask

  task automatic do_load(input logic [2:0] w, input int sel, input string tag);
    load_chk(w, sel, ref_load(w, sel), tag);
  endtask

  task automatic do_store(input logic [2:0] w, input int sel, input logic [31:0] data, input string tag);
    @(negedge clk);
    mode    = 1'b0;
    width   = w;
    select  = 6'(sel);
    in_data = data;
    #1;
    check({tag, "_wr_out_pre"}, out, 32'h0);
    @(posedge clk);
    #1;
    check({tag, "_wr_out_post"}, out, 32'h0);
    ref_store(w, sel, data);
    $display("store w=%0d sel=%0d in=%h", w, sel, data);
  endtask

  task automatic do_reset(input int sel, input logic [31:0] data);
    @(negedge clk);
    rst     = 1'b1;
    mode    = 1'b0;
    width   = 3'd2;
    select  = 6'(sel);
    in_data = data;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 64; i++) model[i] = 0;
    $display("reset with concurrent store sel=%0d in=%h", sel, data);
  endtask

  task automatic dump(input string tag);
    for (int a = 0; a < 16; a++) do_load(3'd2, 4 * a, tag);
  endtask

  initial begin
    rst     = 1'b1;
    mode    = 1'b1;
    width   = 3'd2;
    select  = '0;
    in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 64; i++) model[i] = 0;
    dump("reset_state");

    do_store(3'd2, 0, 32'h0a0a0a0a, "sw0");
    load_chk(3'd5, 0, 32'h00000a0a, "sw_lhu");
    load_chk(3'd4, 0, 32'h0000000a, "sw_lbu");
    load_chk(3'd2, 0, 32'h0a0a0a0a, "sw_lw");

    do_store(3'd1, 0, 32'h00000b0b, "sh0");
    load_chk(3'd5, 0, 32'h00000b0b, "sh_lhu");
    load_chk(3'd4, 0, 32'h0000000b, "sh_lbu");
    load_chk(3'd2, 0, 32'h0a0a0b0b, "sh_lw");

    do_store(3'd0, 5, 32'h00000080, "sb5");
    load_chk(3'd0, 5, 32'hffffff80, "sext_lb");
    load_chk(3'd4, 5, 32'h00000080, "zext_lbu");
    do_store(3'd1, 8, 32'h00008001, "sh8");
    load_chk(3'd1, 8, 32'hffff8001, "sext_lh");
    load_chk(3'd5, 8, 32'h00008001, "zext_lhu");

    do_store(3'd2, 62, 32'h11223344, "wrap");
`ifndef DATA_CACHE_ALIGN_CHECK_EN
    load_chk(3'd2, 62, 32'h11223344, "wrap_lw");
    load_chk(3'd4, 63, 32'h00000033, "wrap_b63");
    load_chk(3'd4, 0, 32'h00000022, "wrap_b0");
`endif
    do_load(3'd2, 62, "wrap_lw_ref");
    for (int a = 0; a < 3; a++) do_load(3'd4, (62 + a) % 64, "wrap_byte");
    do_load(3'd4, 2, "wrap_iso_b2");
    dump("wrap_dump");

    do_store(3'd2, 4, 32'hdeadbeef, "pre_rst");
    load_chk(3'd2, 4, 32'hdeadbeef, "pre_rst_lw");
    do_reset(4, 32'h12345678);
    load_chk(3'd2, 4, 32'h00000000, "rst_prio");
    dump("post_rst");

    do_store(3'd2, 8, 32'hcafef00d, "ill_seed");
    do_store(3'd3, 8, 32'hffffffff, "ill_w3");
    do_store(3'd6, 9, 32'hffffffff, "ill_w6");
    do_store(3'd7, 10, 32'hffffffff, "ill_w7");
    load_chk(3'd2, 8, 32'hcafef00d, "ill_unchanged");
    load_chk(3'd7, 8, 32'h00000000, "ill_rd7");
    load_chk(3'd3, 8, 32'h00000000, "ill_rd3");

    for (int it = 0; it < 600; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) do_reset($urandom_range(0, 63), $urandom);
      else if (r < 50) do_store(3'($urandom_range(0, 7)), $urandom_range(0, 63), $urandom, "rnd_st");
      else do_load(3'($urandom_range(0, 7)), $urandom_range(0, 63), "rnd_ld");
    end
    dump("final_dump");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
